// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type, data width and counter-width helper for uart_tx
package uart_tx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO; a read on a full FIFO frees the slot for a same-cycle write
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_full  = r_cnt == FULL_CNT;
    assign o_empty = r_cnt == '0;
    assign o_data  = r_mem[r_rp];
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    // storage array; contents need no reset because the count gates every read
    always_ff @(posedge i_clk) begin
        if (w_do_wr)
            r_mem[r_wp] <= i_data;
    end

    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_wr)
                r_wp <= r_wp + 1'b1;
            if (w_do_rd)
                r_rp <= r_rp + 1'b1;
            r_cnt <= (w_do_wr && !w_do_rd) ? r_cnt + 1'b1 :
                     (!w_do_wr && w_do_rd) ? r_cnt - 1'b1 : r_cnt;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8-bit UART transmitter; define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_PER_BIT = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int NSTOP       = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_data,
    input  logic        i_wr,
    output logic        o_full,
    output logic        o_idle,
    output logic        o_uart_tx
);

    localparam int BW = cnt_w(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(NSTOP - 1);

    state_t            r_state;
    logic [BW-1:0]     r_baud;
    logic [2:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_idle;
    logic [DATA_W-1:0] w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_tick;
    logic              w_frame_end;
    logic              w_pop;
    logic              w_bit;

    assign w_tick      = r_baud == '0;
    assign w_frame_end = (r_state == STOP) && w_tick && (r_bit == STOP_LAST);
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);
    assign o_full      = w_full;
    assign o_idle      = r_idle;
    assign o_uart_tx   = r_tx;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (i_wr),
        .i_data  (i_data),
        .i_rd    (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef UART_TX_PARITY_EN
    logic r_par;

    // even parity of the byte, captured as it leaves the FIFO
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_par <= 1'b0;
        else if (w_pop)
            r_par <= ^w_head;
    end

    assign w_bit = (r_state == START)  ? 1'b0 :
                   (r_state == DATA)   ? r_shift[0] :
                   (r_state == PARITY) ? r_par : 1'b1;
`else
    assign w_bit = (r_state == START) ? 1'b0 :
                   (r_state == DATA)  ? r_shift[0] : 1'b1;
`endif

    // frame sequencer: the line is a registered copy of the current state's bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_idle  <= 1'b1;
        end else begin
            r_tx   <= w_bit;
            r_idle <= (r_state == IDLE) && w_empty;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_baud  <= BAUD_MAX;
                        r_bit   <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    r_baud  <= w_tick ? BAUD_MAX : r_baud - 1'b1;
                    r_state <= w_tick ? DATA : START;
                end
                DATA: begin
                    if (w_tick) begin
                        r_baud  <= BAUD_MAX;
                        r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7)
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_baud  <= w_tick ? BAUD_MAX : r_baud - 1'b1;
                    r_bit   <= '0;
                    r_state <= w_tick ? STOP : PARITY;
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_baud <= BAUD_MAX;
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            r_state <= w_pop ? START : IDLE;
                            if (w_pop)
                                r_shift <= w_head;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed-vector bench for uart_tx (single and double stop-bit instances)
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LEN1 = (9 + P + 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic       wr = 1'b0;
    logic       full;
    logic       idle;
    logic       tx;
    logic [7:0] data2 = '0;
    logic       wr2 = 1'b0;
    logic       full2;
    logic       idle2;
    logic       tx2;
    logic       sel = 1'b0;
    logic       line;
    int         n_vec = 0;
    int         n_err = 0;

    assign line = sel ? tx2 : tx;

    always #5 clk = ~clk;

    uart_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .NSTOP(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_wr(wr),
        .o_full(full), .o_idle(idle), .o_uart_tx(tx)
    );

    uart_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .NSTOP(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_data(data2), .i_wr(wr2),
        .o_full(full2), .o_idle(idle2), .o_uart_tx(tx2)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        data = b;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic push2(input logic [7:0] b);
        data2 = b;
        wr2 = 1'b1;
        tick();
        wr2 = 1'b0;
    endtask

    // called just after the edge that put the start bit on the selected line
    task automatic check_frame(input logic [7:0] b, input int ns);
        int   nb;
        logic e;
        nb = 9 + P + ns;
        for (int i = 0; i < nb; i++) begin
            e = (i == 0) ? 1'b0 : (i < 9) ? b[i-1] : (P == 1 && i == 9) ? ^b : 1'b1;
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("frame_%02h_bit%0d", b, i), {7'b0, line}, {7'b0, e});
                tick();
            end
        end
    endtask

    // fill the FIFO behind a primer frame so the sixth write lands on the first pop
    task automatic burst(input logic [47:0] vals, input logic [5:0] en);
        push(8'hFF);
        repeat (LEN1 - 5) tick();
        for (int i = 0; i < 6; i++) begin
            if (en[i])
                push(vals[8*i +: 8]);
            else
                tick();
            check($sformatf("burst_full_%0d", i), {7'b0, full}, {7'b0, i >= 3});
        end
        check("burst_primer_stop", {7'b0, tx}, 8'h01);
        tick();
        sel = 1'b0;
        for (int i = 0; i < 6; i++)
            if (i != 4)
                check_frame(vals[8*i +: 8], 1);
        check("burst_idle", {7'b0, idle}, 8'h01);
        check("burst_line", {7'b0, tx}, 8'h01);
    endtask

    initial begin
        logic seen0;
        tick();
        tick();
        check("rst_tx", {7'b0, tx}, 8'h01);
        check("rst_full", {7'b0, full}, 8'h00);
        check("rst_idle", {7'b0, idle}, 8'h01);
        rst = 1'b0;
        tick();

        push(8'hA5);
        check("lat_idle_n", {7'b0, idle}, 8'h01);
        tick();
        check("lat_idle_n1", {7'b0, idle}, 8'h00);
        check("lat_tx_n1", {7'b0, tx}, 8'h01);
        tick();
        check_frame(8'hA5, 1);
        check("a5_idle_after", {7'b0, idle}, 8'h01);

        push(8'h07);
        tick();
        tick();
        check_frame(8'h07, 1);
        check("07_idle_after", {7'b0, idle}, 8'h01);

        burst(48'h06_05_04_03_02_01, 6'b111111);
        burst(48'h77_00_44_33_22_11, 6'b101111);

        push(8'h35);
        push(8'h5A);
        push(8'h96);
        check("rst_mid_full_before", {7'b0, full}, 8'h00);
        repeat (17) tick();
        check("rst_mid_bit3", {7'b0, tx}, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_tx", {7'b0, tx}, 8'h01);
        check("rst_mid_idle", {7'b0, idle}, 8'h01);
        check("rst_mid_full", {7'b0, full}, 8'h00);
        seen0 = 1'b0;
        for (int i = 0; i < 3 * LEN1; i++) begin
            tick();
            if (tx !== 1'b1)
                seen0 = 1'b1;
        end
        check("rst_mid_no_frame", {7'b0, seen0}, 8'h00);
        check("rst_mid_idle_late", {7'b0, idle}, 8'h01);

        sel = 1'b1;
        push2(8'hC3);
        push2(8'h5A);
        tick();
        check_frame(8'hC3, 2);
        check_frame(8'h5A, 2);
        check("nstop2_idle", {7'b0, idle2}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter peripheral for the 9x8 processor core. The core writes bytes through an output-port strobe into a small FIFO. The block serializes them LSB-first as 8-bit asynchronous frames on a single line. FIFO-full and idle status return to the core through an input port so firmware can poll before writing.

## Interface
Parameters:
- CLK_PER_BIT, 16: i_clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4: FIFO entries; power of two, minimum 2.
- NSTOP, 1: stop bits per frame; 1 or 2.

Ports:
- i_clk  input  1  processor clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  8  byte to transmit; sampled when i_wr is high.
- i_wr  input  1  one-cycle outport write strobe.
- o_full  output  1  FIFO full; a write while high is discarded.
- o_idle  output  1  FIFO empty and no frame in progress.
- o_uart_tx  output  1  serial line; idles high.

## Operation
- Reset values: o_uart_tx=1, o_full=0, o_idle=1, FIFO empty, FSM in IDLE, all counters 0.
- FIFO write: on i_wr with o_full=0, push i_data. On i_wr with o_full=1, drop the byte with no state change.
- Simultaneous pop and write while full: the pop frees a slot, so the write is accepted and the count is unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: line 0 for CLK_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLK_PER_BIT cycles each, then PARITY (when the feature is compiled in) or STOP.
  - PARITY: 1 bit, then STOP.
  - STOP: line 1 for NSTOP*CLK_PER_BIT cycles. At the end, pop and go directly to START if the FIFO is non-empty, else go to IDLE.
- Baud counter: counts down from CLK_PER_BIT-1 to 0, reloads each bit, width $clog2(CLK_PER_BIT). Bit counter is 3 bits.
- FIFO count width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: the line returns to 1 on the next edge, the FIFO is flushed, and no partial frame resumes.

## Timing
- All outputs are registered.
- Write latency: i_wr at edge N into an empty, idle block gives o_idle=0 after edge N+1 and the start bit (o_uart_tx=0) after edge N+2.
- o_full asserts the cycle after the write that fills the FIFO. It deasserts the cycle after the pop that frees a slot.
- Frame length is (1+8+P+NSTOP)*CLK_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back frames have zero gap: the next start bit follows the final stop-bit cycle.
- o_idle rises the cycle after the final stop-bit cycle of the last queued byte.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: an even-parity bit (XOR of the 8 data bits) is inserted between the data bits and the stop bits, and the PARITY state exists.
  - Undefined: no PARITY state, no parity logic, and the frame is 1 bit shorter.

## Structure
- Package uart_tx_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - a data-width constant of 8;
  - a counter-width function wrapping $clog2.
- One sub-module, uart_tx_fifo: synchronous FIFO with parameters WIDTH and DEPTH, and ports i_clk, i_rst, i_wr, i_data, i_rd, o_data, o_full, o_empty.
- The FSM, baud counter and shift register live in uart_tx.

## Test plan
- CLK_PER_BIT=4, NSTOP=1, no parity. Write 0xA5 once. Expected: 40-cycle frame on o_uart_tx of 0, 1,0,1,0,0,1,0,1, 1, with each bit held 4 cycles; o_idle rises after it.
- FIFO_DEPTH=4. Write 0x01..0x06 on consecutive cycles. Expected: o_full asserts after the 4th write, the 5th write is dropped, and 0x01, 0x02, 0x03, 0x04 and 0x06 are sent back-to-back with no idle gap. The 6th write (0x06) is accepted because the first pop has freed a slot by then.
- FIFO full and the first pop on the same cycle as i_wr=0x77. Expected: the write is accepted, o_full stays 1, and 0x77 is transmitted last.
- Assert i_rst during bit 3 of a frame with 2 bytes queued. Expected: o_uart_tx=1 the next cycle, o_idle=1, o_full=0, and no further frames.
- With UART_TX_PARITY_EN, send 0x07. Expected: parity bit 1 after the data bits, 11-bit frame.
- NSTOP=2, two writes. Expected: stop interval of 8 cycles before the second start bit.
